// File: rtl/archie_mem_sched_if.sv
// Signal bundle shared by the SDRAM port scheduler, the core wishbone master,
// the ROM loader (hps_io ioctl) and the SDRAM controller wishbone port.
interface archie_mem_sched_if;
  logic        ram_ready;
  logic        ld_active;
  logic        ld_wr;
  logic [21:0] ld_addr;
  logic [15:0] ld_data;
  logic        ld_busy;

  logic        cpu_cyc;
  logic        cpu_stb;
  logic        cpu_we;
  logic [3:0]  cpu_sel;
  logic [2:0]  cpu_cti;
  logic [21:0] cpu_adr;
  logic [31:0] cpu_dat;
  logic        cpu_ack;
  logic        cpu_hold;

  logic        ram_cyc;
  logic        ram_stb;
  logic        ram_we;
  logic [3:0]  ram_sel;
  logic [2:0]  ram_cti;
  logic [23:0] ram_adr;
  logic [31:0] ram_dat;
  logic        ram_ack;

  // scheduler side
  modport slave (
    input  ram_ready, ld_active, ld_wr, ld_addr, ld_data,
    input  cpu_cyc, cpu_stb, cpu_we, cpu_sel, cpu_cti, cpu_adr, cpu_dat,
    input  ram_ack,
    output ld_busy, cpu_ack, cpu_hold,
    output ram_cyc, ram_stb, ram_we, ram_sel, ram_cti, ram_adr, ram_dat
  );

  // environment side: core, loader and SDRAM controller
  modport master (
    output ram_ready, ld_active, ld_wr, ld_addr, ld_data,
    output cpu_cyc, cpu_stb, cpu_we, cpu_sel, cpu_cti, cpu_adr, cpu_dat,
    output ram_ack,
    input  ld_busy, cpu_ack, cpu_hold,
    input  ram_cyc, ram_stb, ram_we, ram_sel, ram_cti, ram_adr, ram_dat
  );
endinterface

// File: rtl/archie_mem_sched.sv
// SDRAM wishbone port scheduler: core pass-through, or ROM download (optional RAM
// erase, then 16-bit loader writes into the ROM window). ARCHIE_MEM_ERASE_EN builds the erase phase.
//
//  state  | meaning
//  CPU    | core owns the port, ram_* mirror cpu_*
//  DRAIN  | download requested, core cycle still open; core held, pass-through kept
//  ERASE  | zero-fill words 0..ERASE_WORDS-1 (ARCHIE_MEM_ERASE_EN only)
//  LWAIT  | port idle, waiting for the next loader halfword
//  LWRITE | one loader halfword write on the port
module archie_mem_sched #(
  parameter int          ERASE_WORDS = 1048576,
  parameter logic [23:0] ROM_BASE    = 24'h100000
) (
  input logic               clk_sys,
  input logic               reset,
  archie_mem_sched_if.slave bus
);

`ifdef ARCHIE_MEM_ERASE_EN
  typedef enum logic [2:0] {S_CPU, S_DRAIN, S_ERASE, S_LWAIT, S_LWRITE} state_t;
  localparam int CNT_W = $clog2(ERASE_WORDS);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(ERASE_WORDS - 1);
  logic [CNT_W-1:0] erase_cnt;
`else
  typedef enum logic [2:0] {S_CPU, S_DRAIN, S_LWAIT, S_LWRITE} state_t;
`endif

  state_t      state;
  logic        ld_active_q;
  logic        cpu_hold_q;
  logic        busy_q;
  logic [19:0] ld_word_q;
  logic        ld_hi_q;
  logic [15:0] ld_data_q;
  logic        ack_taken;
  logic        ld_rise;
  logic        unused_bits;

  // loader strobes are only visible while ram_ready is high, so an ack counts only then
  assign ack_taken   = bus.ram_ack & bus.ram_ready;
  assign ld_rise     = bus.ld_active & ~ld_active_q;
  assign unused_bits = bus.ld_addr[0] & (ERASE_WORDS > 1);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state       <= S_CPU;
      ld_active_q <= 1'b0;
      cpu_hold_q  <= 1'b0;
      busy_q      <= 1'b0;
      ld_word_q   <= '0;
      ld_hi_q     <= 1'b0;
      ld_data_q   <= '0;
`ifdef ARCHIE_MEM_ERASE_EN
      erase_cnt   <= '0;
`endif
    end else begin
      ld_active_q <= bus.ld_active;
      case (state)
        S_CPU: begin
          if (ld_rise) begin
            state      <= S_DRAIN;
            cpu_hold_q <= 1'b1;
            busy_q     <= 1'b1;
`ifdef ARCHIE_MEM_ERASE_EN
            erase_cnt  <= '0;
`endif
          end
        end

        S_DRAIN: begin
          if (!bus.cpu_cyc) begin
            // a download that was withdrawn while draining never touches RAM
            if (!bus.ld_active) begin
              state      <= S_CPU;
              cpu_hold_q <= 1'b0;
              busy_q     <= 1'b0;
            end else begin
`ifdef ARCHIE_MEM_ERASE_EN
              state  <= S_ERASE;
`else
              state  <= S_LWAIT;
              busy_q <= 1'b0;
`endif
            end
          end
        end

`ifdef ARCHIE_MEM_ERASE_EN
        S_ERASE: begin
          if (ack_taken) begin
            erase_cnt <= erase_cnt + 1'b1;
            if (!bus.ld_active) begin
              state      <= S_CPU;
              cpu_hold_q <= 1'b0;
              busy_q     <= 1'b0;
            end else if (erase_cnt == LAST_WORD) begin
              state  <= S_LWAIT;
              busy_q <= 1'b0;
            end
          end else if (!bus.ld_active && !bus.ram_ready) begin
            state      <= S_CPU;
            cpu_hold_q <= 1'b0;
            busy_q     <= 1'b0;
          end
        end
`endif

        S_LWAIT: begin
          if (!bus.ld_active) begin
            state      <= S_CPU;
            cpu_hold_q <= 1'b0;
          end else if (bus.ld_wr) begin
            state     <= S_LWRITE;
            busy_q    <= 1'b1;
            ld_word_q <= bus.ld_addr[21:2];
            ld_hi_q   <= bus.ld_addr[1];
            ld_data_q <= bus.ld_data;
          end
        end

        S_LWRITE: begin
          if (ack_taken) begin
            busy_q <= 1'b0;
            if (!bus.ld_active) begin
              state      <= S_CPU;
              cpu_hold_q <= 1'b0;
            end else begin
              state <= S_LWAIT;
            end
          end else if (!bus.ld_active && !bus.ram_ready) begin
            state      <= S_CPU;
            cpu_hold_q <= 1'b0;
            busy_q     <= 1'b0;
          end
        end

        default: begin
          state      <= S_CPU;
          cpu_hold_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  // DRAIN keeps forwarding acks so an open core burst can finish
  always_comb begin
    bus.ram_cyc = bus.cpu_cyc;
    bus.ram_stb = bus.cpu_stb;
    bus.ram_we  = bus.cpu_we;
    bus.ram_sel = bus.cpu_sel;
    bus.ram_cti = bus.cpu_cti;
    bus.ram_adr = {2'b00, bus.cpu_adr};
    bus.ram_dat = bus.cpu_dat;
    bus.cpu_ack = 1'b0;
    case (state)
      S_CPU, S_DRAIN: bus.cpu_ack = bus.ram_ack;
      S_LWAIT: begin
        bus.ram_cyc = 1'b0;
        bus.ram_stb = 1'b0;
        bus.ram_we  = 1'b0;
        bus.ram_sel = 4'h0;
        bus.ram_cti = 3'b000;
        bus.ram_adr = 24'h0;
        bus.ram_dat = 32'h0;
      end
`ifdef ARCHIE_MEM_ERASE_EN
      S_ERASE: begin
        bus.ram_cyc = bus.ram_ready;
        bus.ram_stb = bus.ram_ready;
        bus.ram_we  = 1'b1;
        bus.ram_sel = 4'hF;
        bus.ram_cti = 3'b000;
        bus.ram_adr = 24'(erase_cnt);
        bus.ram_dat = 32'h0;
      end
`endif
      S_LWRITE: begin
        bus.ram_cyc = bus.ram_ready;
        bus.ram_stb = bus.ram_ready;
        bus.ram_we  = 1'b1;
        bus.ram_sel = ld_hi_q ? 4'b1100 : 4'b0011;
        bus.ram_cti = 3'b000;
        bus.ram_adr = ROM_BASE + {4'b0000, ld_word_q};
        bus.ram_dat = {ld_data_q, ld_data_q};
      end
      default: ;
    endcase
  end

  assign bus.ld_busy  = busy_q | (state == S_LWAIT && bus.ld_active && bus.ld_wr);
  assign bus.cpu_hold = cpu_hold_q;

endmodule
